// File: rtl/valid_ready_deserializer.sv
// Packs BEATS narrow valid/ready beats into one wide registered word.
// An i_last beat ends a word early; the unused upper beats are zeroed and the word is flagged short.
module valid_ready_deserializer #(
  parameter int IN_WIDTH = 32,
  parameter int BEATS    = 4,
  localparam int OUT_WIDTH = IN_WIDTH * BEATS,
  localparam int CNT_WIDTH = $clog2(BEATS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [IN_WIDTH-1:0]  i_data,
  input  logic                 i_last,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_short
);

  if (BEATS < 2) begin : g_bad_beats
    $error("valid_ready_deserializer: BEATS must be >= 2");
  end

  logic [(BEATS-1)*IN_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0]          acc_ext;
  logic [CNT_WIDTH-1:0]          cnt;
  logic [CNT_WIDTH-1:0]          cnt_inc;
  logic                          completing;
  logic                          slot_free;
  logic                          accept;
  logic [OUT_WIDTH-1:0]          word_next;

  // Only a completing beat needs the output slot; partial beats go to acc.
  assign completing = (cnt == CNT_WIDTH'(BEATS - 1)) | i_last;
  assign slot_free  = ~o_valid | o_ready;
  assign i_ready    = ~completing | slot_free;
  assign accept     = i_valid & i_ready;
  assign cnt_inc    = cnt + CNT_WIDTH'(1);
  assign acc_ext    = {{IN_WIDTH{1'b0}}, acc};

  always_comb begin
    word_next = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (CNT_WIDTH'(k) < cnt)
        word_next[k*IN_WIDTH +: IN_WIDTH] = acc_ext[k*IN_WIDTH +: IN_WIDTH];
      else if (CNT_WIDTH'(k) == cnt)
        word_next[k*IN_WIDTH +: IN_WIDTH] = i_data;
    end
  end

  // Output register stage: a completing beat loads the word, else a handshake drains it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_count <= '0;
      o_short <= 1'b0;
    end else if (accept && completing) begin
      o_data  <= word_next;
      o_count <= cnt_inc;
      o_short <= (cnt_inc < CNT_WIDTH'(BEATS));
      o_valid <= 1'b1;
      cnt     <= '0;
      acc     <= '0;
    end else begin
      if (accept) begin
        for (int k = 0; k < BEATS - 1; k++) begin
          if (cnt == CNT_WIDTH'(k))
            acc[k*IN_WIDTH +: IN_WIDTH] <= i_data;
        end
        cnt <= cnt_inc;
      end
      if (o_valid && o_ready)
        o_valid <= 1'b0;
    end
  end

endmodule

// File: doc/valid_ready_deserializer.md
Name: valid_ready_deserializer

Overview:
- Receive-side width converter for the coefficient datapath.
- Collects BEATS narrow beats (e.g. one 4-coefficient row per beat) from a valid/ready stream and packs them into one wide word (e.g. a full 128-bit 4x4 block).
- Presents the wide word on a registered valid/ready output that feeds the 128-bit pipeline stages.
- Supports early termination via i_last: a partial word is zero-padded and flagged.

Parameters:
- IN_WIDTH, 32, width of one input beat.
- BEATS, 4, beats per output word; must be >= 2.
- (derived, not overridable) OUT_WIDTH = IN_WIDTH*BEATS.
- (derived, not overridable) CNT_WIDTH = $clog2(BEATS+1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0); all state clears immediately on assertion.
- i_valid  input  1  input beat valid.
- i_ready  output  1  input beat accepted when i_valid & i_ready at a clk edge.
- i_data  input  IN_WIDTH  input beat payload.
- i_last  input  1  final beat of the current word (early termination allowed).
- o_valid  output  1  registered; output word valid.
- o_ready  input  1  downstream accepts the output word.
- o_data  output  OUT_WIDTH  registered packed word; beat k occupies bits [k*IN_WIDTH +: IN_WIDTH].
- o_count  output  CNT_WIDTH  registered; number of real beats in o_data (1..BEATS).
- o_short  output  1  registered; 1 when o_count < BEATS.

Behaviour:
- Internal state:
  - acc: (BEATS-1)*IN_WIDTH accumulator, separate from the output register.
  - cnt: 0..BEATS-1, index of the next beat.
- Reset (asynchronous): o_valid=0, o_data=0, o_count=0, o_short=0, cnt=0, acc=0. Any partial word in progress is discarded; no output is produced for it.
- Definitions:
  - completing = (cnt == BEATS-1) | i_last.
  - slot_free = ~o_valid | o_ready.
  - i_ready = ~completing | slot_free.
  - i_ready is combinational from cnt, o_valid, o_ready and i_last. It never depends on i_valid.
- Accepted non-completing beat:
  - acc[cnt] <= i_data; cnt <= cnt+1.
  - The output register is untouched by the beat; it still follows the drain rule below.
- Accepted completing beat:
  - o_data <= beats 0..cnt-1 from acc, beat cnt = i_data, all higher beats = 0.
  - o_count <= cnt+1; o_short <= (cnt+1 < BEATS); o_valid <= 1.
  - cnt <= 0; acc <= 0.
- i_last with cnt == BEATS-1: normal full word, o_short=0.
- Drain: o_valid & o_ready with no completing beat accepted in the same cycle -> o_valid <= 0. o_data, o_count and o_short hold their last values.
- Simultaneous drain and completion: the new word replaces the old one in the same edge and o_valid stays 1. This gives zero-bubble streaming.
- While o_valid=1 and o_ready=0:
  - o_data, o_count and o_short are held stable.
  - Non-completing beats continue to be accepted into acc.
  - A completing beat stalls (i_ready=0) until o_ready=1.
- Latency: o_valid rises on the clk edge that accepts the completing beat; the word is visible the cycle after the last beat.
- Throughput: 1 input beat per cycle sustained when o_ready=1; one output word every BEATS cycles.
- Beats presented with i_valid=0 are ignored. i_data and i_last are don't-care when i_valid=0.
- No overflow is possible; no underflow is possible (output only exists after a completing beat).

Test Plan:
- Full word: beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 back-to-back, o_ready=1 -> one cycle after the 4th beat, o_valid=1, o_data=0x44444444_33333333_22222222_11111111, o_count=4, o_short=0, i_ready=1 throughout.
- Early termination: beats 0xAAAA0001, then 0xAAAA0002 with i_last=1 -> o_data=0x00000000_00000000_AAAA0002_AAAA0001, o_count=2, o_short=1. Next word starts at beat 0.
- Single-beat word: one beat 0xDEADBEEF with i_last=1 -> o_data=0x0..0_DEADBEEF, o_count=1, o_short=1.
- Backpressure: first word completes, then o_ready=0 with i_valid held 1 -> next 3 beats accepted, i_ready=0 on the 4th, o_data stable. Raise o_ready -> 4th beat accepted in that cycle, the second word replaces the first, o_valid stays 1.
- Streaming: 12 consecutive beats with o_ready=1 -> i_ready never drops; 3 words with o_valid pulses of 1 cycle each, 4 cycles apart, correct packing.
- Reset mid-word: 2 beats accepted, then reset=0 for 1 cycle -> all outputs 0 immediately. Then 4 new beats -> output contains only the new beats, o_count=4.
